// File: rtl/cordic_pkg.sv
// Shared constants, types and helpers for the CORDIC sin/cos path.
// Angles and results are signed Q1.14.
package cordic_pkg;

  localparam int HALF_PI_Q14  = 25736;
  localparam int CORDIC_K_Q14 = 9949;
  localparam int CORDIC_ITERS = 8;

  typedef logic [1:0] quad_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  function automatic logic signed [15:0] neg_sat(
    input logic signed [15:0] v
  );
    logic signed [15:0] r;
    if (v == 16'sh8000) r = 16'sh7fff;
    else r = -v;
    return r;
  endfunction

  // atan(2^-i) in Q1.14
  function automatic logic signed [15:0] atan_q14(
    input logic [2:0] i
  );
    logic signed [15:0] r;
    r = '0;
    case (i)
      3'd0: r = 16'sd12868;
      3'd1: r = 16'sd7596;
      3'd2: r = 16'sd4014;
      3'd3: r = 16'sd2037;
      3'd4: r = 16'sd1023;
      3'd5: r = 16'sd512;
      3'd6: r = 16'sd256;
      3'd7: r = 16'sd128;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cordic_sin_cos.sv
// Iterative rotation-mode CORDIC core, one iteration per cycle.
// done is a level, cleared when a new start is accepted.
module cordic_sin_cos
  import cordic_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [15:0] angle,
  output logic               done,
  output logic signed [15:0] cos,
  output logic signed [15:0] sin
);

  logic signed [15:0] x, y, z;
  logic signed [15:0] xs, ys;
  logic [2:0] iter;
  logic       busy;
  logic       dir;

  assign xs  = x >>> iter;
  assign ys  = y >>> iter;
  assign dir = ~z[15];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x    <= '0;
      y    <= '0;
      z    <= '0;
      iter <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      x    <= 16'(CORDIC_K_Q14);
      y    <= '0;
      z    <= angle;
      iter <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      if (dir) begin
        x <= x - ys;
        y <= y + xs;
        z <= z - atan_q14(iter);
      end else begin
        x <= x + ys;
        y <= y - xs;
        z <= z + atan_q14(iter);
      end
      iter <= iter + 3'd1;
      if (iter == 3'(CORDIC_ITERS - 1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign cos = x;
  assign sin = y;

endmodule

// File: rtl/cordic_phase_frontend.sv
// Phase accumulator and quadrant folding in front of cordic_sin_cos;
// launches one conversion per accepted tick and unfolds the result.
module cordic_phase_frontend
  import cordic_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [ACC_W-1:0]   phase_inc,
  input  logic [15:0]        phase_ofs,
  output logic               cordic_start,
  output logic signed [15:0] cordic_angle,
  input  logic               cordic_done,
  input  logic signed [15:0] cordic_cos,
  input  logic signed [15:0] cordic_sin,
  output logic signed [15:0] cos_out,
  output logic signed [15:0] sin_out,
  output logic               out_valid,
  output logic               overrun
);

  state_t state, state_nxt;

  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_nxt;
  logic [15:0]        pw;
  logic [28:0]        prod;
  logic signed [15:0] angle_nxt;
  quad_t              quad;
  logic signed [15:0] cos_nxt, sin_nxt;

  assign acc_nxt   = acc + phase_inc;
  assign pw        = acc_nxt[ACC_W-1 -: 16] + phase_ofs;
  assign prod      = {15'd0, pw[13:0]} * 29'(HALF_PI_Q14);
  assign angle_nxt = {1'b0, prod[28:14]};

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (tick) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cordic_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Rotate the first-quadrant result back by quad * 90 degrees.
  always_comb begin
    cos_nxt = cordic_cos;
    sin_nxt = cordic_sin;
    unique case (quad)
      2'd0: begin
        cos_nxt = cordic_cos;
        sin_nxt = cordic_sin;
      end
      2'd1: begin
        cos_nxt = neg_sat(cordic_sin);
        sin_nxt = cordic_cos;
      end
      2'd2: begin
        cos_nxt = neg_sat(cordic_cos);
        sin_nxt = neg_sat(cordic_sin);
      end
      2'd3: begin
        cos_nxt = cordic_sin;
        sin_nxt = neg_sat(cordic_cos);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      acc          <= '0;
      quad         <= '0;
      cordic_angle <= '0;
      cos_out      <= '0;
      sin_out      <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      if (tick) acc <= acc_nxt;
      if (tick && state != IDLE) overrun <= 1'b1;
      if (tick && state == IDLE) begin
        quad         <= pw[15:14];
        cordic_angle <= angle_nxt;
      end
      if (state == WAIT && cordic_done) begin
        cos_out   <= cos_nxt;
        sin_out   <= sin_nxt;
        out_valid <= 1'b1;
      end
    end
  end

  assign cordic_start = (state == ISSUE);

endmodule

// File: tb/tb_cordic_phase_frontend.sv
// Directed bench for cordic_phase_frontend driving a cordic_sin_cos core.
// Vector table plus hand-written overrun and reset sequences.
module tb_cordic_phase_frontend;
  import cordic_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic [23:0] phase_inc = '0;
  logic [15:0] phase_ofs = '0;
  logic cordic_start, cordic_done;
  logic signed [15:0] cordic_angle, cordic_cos, cordic_sin;
  logic signed [15:0] cos_out, sin_out;
  logic out_valid, overrun;

  int total = 0;
  int passed = 0;
  int n_start = 0;
  int n_valid = 0;
  logic [23:0] acc_m = '0;

  typedef struct {
    logic [15:0] ofs;
    logic [23:0] inc;
    int angle;
    int c;
    int s;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cordic_start) n_start++;
    if (out_valid) n_valid++;
  end

  cordic_phase_frontend #(.ACC_W(24)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .phase_inc    (phase_inc),
    .phase_ofs    (phase_ofs),
    .cordic_start (cordic_start),
    .cordic_angle (cordic_angle),
    .cordic_done  (cordic_done),
    .cordic_cos   (cordic_cos),
    .cordic_sin   (cordic_sin),
    .cos_out      (cos_out),
    .sin_out      (sin_out),
    .out_valid    (out_valid),
    .overrun      (overrun)
  );

  cordic_sin_cos core (
    .clk   (clk),
    .reset (reset),
    .start (cordic_start),
    .angle (cordic_angle),
    .done  (cordic_done),
    .cos   (cordic_cos),
    .sin   (cordic_sin)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_tol(input string name, input int act,
                         input int exp, input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    total++;
    if (d <= tol) passed++;
    else $display("FAIL %s: got %0d expected %0d +/-%0d",
                  name, act, exp, tol);
  endtask

  task automatic conv(input string name, input logic [15:0] ofs,
                      input logic [23:0] inc, input int ea,
                      input int ec, input int es);
    int lat;
    @(negedge clk);
    phase_ofs = ofs;
    phase_inc = inc;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    acc_m = acc_m + inc;
    chk({name, " start"}, int'(cordic_start), 1);
    chk({name, " angle"}, int'(cordic_angle), ea);
    chk({name, " acc"}, int'(dut.acc), int'(acc_m));
    @(posedge clk);
    #1;
    chk({name, " start_pulse"}, int'(cordic_start), 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, " latency"}, lat, 10);
    chk_tol({name, " cos"}, int'(cos_out), ec, 128);
    chk_tol({name, " sin"}, int'(sin_out), es, 128);
    @(posedge clk);
    #1;
    chk({name, " valid_pulse"}, int'(out_valid), 0);
  endtask

  initial begin
    vecs[0] = '{16'h0000, 24'h000000, 0,     16384,  0};
    vecs[1] = '{16'h4000, 24'h000000, 0,     0,      16384};
    vecs[2] = '{16'h8000, 24'h000000, 0,     -16384, 0};
    vecs[3] = '{16'hC000, 24'h000000, 0,     0,      -16384};
    vecs[4] = '{16'h2000, 24'h000000, 12868, 11585,  11585};
    vecs[5] = '{16'h6000, 24'h000000, 12868, -11585, 11585};
    vecs[6] = '{16'h1000, 24'h000000, 6434,  15137,  6270};
    vecs[7] = '{16'h1000, 24'hFFFFFF, 6432,  15137,  6269};
    vecs[8] = '{16'h1000, 24'h000001, 6434,  15137,  6270};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst cos", int'(cos_out), 0);
    chk("rst sin", int'(sin_out), 0);
    chk("rst valid", int'(out_valid), 0);
    chk("rst start", int'(cordic_start), 0);
    chk("rst overrun", int'(overrun), 0);
    chk("rst angle", int'(cordic_angle), 0);
    chk("rst acc", int'(dut.acc), 0);

    for (int i = 0; i < 9; i++) begin
      conv($sformatf("vec%0d", i), vecs[i].ofs, vecs[i].inc,
           vecs[i].angle, vecs[i].c, vecs[i].s);
    end
    chk("no overrun yet", int'(overrun), 0);

    n_start = 0;
    n_valid = 0;
    @(negedge clk);
    phase_ofs = 16'h0000;
    phase_inc = 24'h000100;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    acc_m = acc_m + 24'h000100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    acc_m = acc_m + 24'h000100;
    chk("ovr flag", int'(overrun), 1);
    repeat (12) @(posedge clk);
    #1;
    chk("ovr starts", n_start, 1);
    chk("ovr valids", n_valid, 1);
    chk("ovr acc", int'(dut.acc), int'(acc_m));
    conv("post_ovr", 16'hFFFE, 24'h000000, 0, 16384, 0);
    chk("ovr sticky", int'(overrun), 1);

    @(negedge clk);
    phase_ofs = 16'h5000;
    phase_inc = 24'h000000;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    acc_m = '0;
    chk("mid cos", int'(cos_out), 0);
    chk("mid sin", int'(sin_out), 0);
    chk("mid valid", int'(out_valid), 0);
    chk("mid start", int'(cordic_start), 0);
    chk("mid angle", int'(cordic_angle), 0);
    chk("mid overrun", int'(overrun), 0);
    chk("mid acc", int'(dut.acc), 0);
    n_valid = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("mid no valid", n_valid, 0);
    conv("after_rst", 16'h8000, 24'h000000, 0, -16384, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cordic_phase_frontend.md
# cordic_phase_frontend

Phase-accumulator and quadrant-folding front end for the iterative CORDIC sin/cos core (`cordic_sin_cos`).
- On each sample tick it advances a phase accumulator, folds the phase word into the first quadrant, and converts it to a Q1.14 radian angle.
- It then launches the core with a one-cycle start and waits for done.
- It applies the quadrant correction to the core's cos/sin results and presents one registered output sample to the downstream consumer.

## Interface
- ACC_W, 24, phase accumulator width; the top 16 bits form the phase word (2^16 = 2π).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  sample strobe; requests one conversion.
- phase_inc  in  ACC_W  unsigned accumulator increment, sampled on accepted and dropped ticks.
- phase_ofs  in  16  phase offset added to the phase word, sampled on accepted ticks.
- cordic_start  out  1  one-cycle start to the core.
- cordic_angle  out  16  signed Q1.14 angle to the core, range 0..25734.
- cordic_done  in  1  core done (level; the core clears it when it accepts start).
- cordic_cos, cordic_sin  in  16  signed Q1.14 core results.
- cos_out, sin_out  out  16  signed Q1.14 quadrant-corrected results.
- out_valid  out  1  one-cycle pulse; cos_out/sin_out valid.
- overrun  out  1  sticky; a tick arrived while not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- Transitions: IDLE -tick-> ISSUE -> WAIT -cordic_done-> IDLE.
- **IDLE + tick:**
  - acc <= acc + phase_inc, modulo 2^ACC_W.
  - pw = acc_new[ACC_W-1 -: 16] + phase_ofs, mod 2^16.
  - Register quad = pw[15:14] and angle = (pw[13:0] * 25736) >> 14, unsigned, 29-bit product.
- **ISSUE:**
  - cordic_start = 1 for exactly one cycle.
  - cordic_angle = registered angle, held stable from ISSUE until return to IDLE.
- **WAIT:** cordic_done is not examined in ISSUE. A stale done from the previous conversion is cleared by the core on the ISSUE edge.
- **On cordic_done in WAIT:** register the corrected outputs (c = cordic_cos, s = cordic_sin), set out_valid, return to IDLE.
  - quad 0: cos=c, sin=s
  - quad 1: cos=-s, sin=c
  - quad 2: cos=-c, sin=-s
  - quad 3: cos=s, sin=-c
  - Negation saturates: -(-32768) = 32767.
- **Tick when not IDLE:**
  - Accumulator still advances by phase_inc.
  - No conversion is launched.
  - overrun <= 1. overrun is cleared only by reset.
- **Reset values:**
  - state = IDLE, acc = 0.
  - cos_out = sin_out = 0.
  - out_valid = cordic_start = overrun = 0, cordic_angle = 0.
- **Reset mid-operation:** everything returns immediately to reset values, with no out_valid. The core shares reset, so no handshake residue remains.

## Timing
- Tick sampled at edge T0 -> ISSUE during T0..T1.
- The core accepts start at T1 and runs 8 iterations on T2..T9; cordic_done is high after T9.
- Corrected outputs and out_valid are registered at T10. out_valid is high for cycle T10..T11 only.
- The FSM is in IDLE after T10, so the next tick is accepted at T11 at the earliest. Maximum rate is one conversion per 11 cycles.
- Tick coincident with the T10 edge (state still WAIT): counts as an overrun.
- cos_out/sin_out hold their value until the next out_valid.

## Structure
- Shared package `cordic_pkg`:
  - HALF_PI_Q14 = 25736
  - CORDIC_K_Q14 = 9949
  - CORDIC_ITERS = 8
  - Quadrant 2-bit type
  - FSM state enum
- No sub-module inside this block. `cordic_sin_cos` is instantiated beside it at the next level up and connected through the cordic_* ports.
- The bench instantiates both.

## Test plan
- **Phase 0:** reset, phase_ofs=0, phase_inc=0, tick -> out_valid exactly 10 cycles after the tick edge; cos_out ≈ 16384 ±128, sin_out ≈ 0 ±128; cordic_angle = 0.
- **Four quadrants:** phase_ofs = 0x4000 / 0x8000 / 0xC000, one tick each -> (cos,sin) ≈ (0,16384), (-16384,0), (0,-16384), each ±128.
- **45°:** phase_ofs = 0x2000 -> cordic_angle = 12868, cos_out ≈ sin_out ≈ 11585 ±128.
- **Accumulator wrap:** acc preloaded to 0xFFFFFF via ticks, then phase_inc = 1 -> acc = 0x000000, pw = phase_ofs.
- **Overrun:** two ticks 3 cycles apart -> only one cordic_start and one out_valid; overrun = 1 and stays set; acc advanced by 2·phase_inc.
- **Reset in WAIT:** reset asserted 5 cycles after start -> all outputs 0 immediately, no out_valid. A subsequent tick produces a normal result 10 cycles later.
